// File: rtl/pin_lock.sv
// PIN-entry lock with a runtime-programmable PIN, failed-attempt counting and a
// timed lockout. A wrong digit is only judged once the whole PIN has been entered.
module pin_lock #(
  parameter int DIGIT_W        = 8,
  parameter int PIN_LEN        = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter logic [DIGIT_W*PIN_LEN-1:0] DEFAULT_PIN = 32'hBAADC0DE
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [DIGIT_W-1:0]                 din,
  input  logic                               din_valid,
  input  logic                               relock,
  input  logic                               prog_en,
  output logic                               unlocked,
  output logic                               locked_out,
  output logic [$clog2(MAX_TRIES+1)-1:0]     fail_count,
  output logic                               prog_done
);

  localparam int PIN_W = DIGIT_W * PIN_LEN;
  localparam int IDX_W = (PIN_LEN > 1) ? $clog2(PIN_LEN) : 1;
  localparam int FC_W  = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIN_LEN - 1);
  localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_ENTRY    = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_PROGRAM  = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_t;

  // Digit 0 lives in the MSBs of the packed PIN.
  function automatic logic [DIGIT_W-1:0] pin_digit(input logic [PIN_W-1:0] pin,
                                                   input logic [IDX_W-1:0] idx);
    logic [DIGIT_W-1:0] d;
    d = '0;
    for (int i = 0; i < PIN_LEN; i++) begin
      d = (int'(idx) == i) ? pin[(PIN_LEN-1-i)*DIGIT_W +: DIGIT_W] : d;
    end
    return d;
  endfunction

  function automatic logic [PIN_W-1:0] pin_set_digit(input logic [PIN_W-1:0]   pin,
                                                     input logic [IDX_W-1:0]   idx,
                                                     input logic [DIGIT_W-1:0] d);
    logic [PIN_W-1:0] p;
    p = pin;
    for (int i = 0; i < PIN_LEN; i++) begin
      p[(PIN_LEN-1-i)*DIGIT_W +: DIGIT_W] =
        (int'(idx) == i) ? d : pin[(PIN_LEN-1-i)*DIGIT_W +: DIGIT_W];
    end
    return p;
  endfunction

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic               r_flag, w_flag_nxt;
  logic [FC_W-1:0]    r_fail, w_fail_nxt;
  logic [PIN_W-1:0]   r_pin, w_pin_nxt;
  logic [PIN_W-1:0]   r_shadow, w_shadow_nxt;
  logic [TMR_W-1:0]   r_timer, w_timer_nxt;
  logic               w_prog_done_nxt;
  logic               r_unlocked, r_locked_out, r_prog_done;

  logic               w_last;
  logic               w_mismatch;
  logic [FC_W-1:0]    w_fail_inc;

  assign w_last     = (r_idx == LAST_IDX);
  assign w_mismatch = r_flag | (din != pin_digit(r_pin, r_idx));
  assign w_fail_inc = (r_fail == FC_MAX) ? r_fail : r_fail + FC_W'(1);

  // Next-state and next-datapath logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_flag_nxt      = r_flag;
    w_fail_nxt      = r_fail;
    w_pin_nxt       = r_pin;
    w_shadow_nxt    = r_shadow;
    w_timer_nxt     = r_timer;
    w_prog_done_nxt = 1'b0;
    case (r_state)
      ST_ENTRY: begin
        if (din_valid) begin
          if (w_last) begin
            w_idx_nxt  = '0;
            w_flag_nxt = 1'b0;
            if (!w_mismatch) begin
              w_state_nxt = ST_UNLOCKED;
              w_fail_nxt  = '0;
            end else begin
              w_fail_nxt = w_fail_inc;
              if (w_fail_inc == FC_MAX) begin
                w_state_nxt = ST_LOCKOUT;
                w_timer_nxt = TMR_LOAD;
              end else begin
                w_state_nxt = ST_ENTRY;
              end
            end
          end else begin
            w_idx_nxt  = r_idx + IDX_W'(1);
            w_flag_nxt = w_mismatch;
          end
        end else begin
          w_state_nxt = ST_ENTRY;
        end
      end
      ST_LOCKOUT: begin
        // Loaded with LOCKOUT_CYCLES, leaves on the cycle it would reach zero.
        if (r_timer <= TMR_W'(1)) begin
          w_state_nxt = ST_ENTRY;
          w_timer_nxt = '0;
          w_fail_nxt  = '0;
          w_idx_nxt   = '0;
          w_flag_nxt  = 1'b0;
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end
      ST_UNLOCKED: begin
        if (relock) begin
          w_state_nxt = ST_ENTRY;
          w_idx_nxt   = '0;
          w_flag_nxt  = 1'b0;
        end else if (prog_en) begin
          w_state_nxt = ST_PROGRAM;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = ST_UNLOCKED;
        end
      end
      ST_PROGRAM: begin
        if (relock) begin
          w_state_nxt = ST_ENTRY;
          w_idx_nxt   = '0;
          w_flag_nxt  = 1'b0;
        end else if (din_valid) begin
          if (w_last) begin
            w_pin_nxt       = pin_set_digit(r_shadow, r_idx, din);
            w_prog_done_nxt = 1'b1;
            w_state_nxt     = ST_UNLOCKED;
            w_idx_nxt       = '0;
          end else begin
            w_shadow_nxt = pin_set_digit(r_shadow, r_idx, din);
            w_idx_nxt    = r_idx + IDX_W'(1);
          end
        end else begin
          w_state_nxt = ST_PROGRAM;
        end
      end
      default: begin
        w_state_nxt = ST_ENTRY;
        w_idx_nxt   = '0;
        w_flag_nxt  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered-output update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_ENTRY;
      r_idx        <= '0;
      r_flag       <= 1'b0;
      r_fail       <= '0;
      r_pin        <= DEFAULT_PIN;
      r_shadow     <= '0;
      r_timer      <= '0;
      r_unlocked   <= 1'b0;
      r_locked_out <= 1'b0;
      r_prog_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_flag       <= w_flag_nxt;
      r_fail       <= w_fail_nxt;
      r_pin        <= w_pin_nxt;
      r_shadow     <= w_shadow_nxt;
      r_timer      <= w_timer_nxt;
      r_unlocked   <= (w_state_nxt == ST_UNLOCKED) || (w_state_nxt == ST_PROGRAM);
      r_locked_out <= (w_state_nxt == ST_LOCKOUT);
      r_prog_done  <= w_prog_done_nxt;
    end
  end

  assign unlocked   = r_unlocked;
  assign locked_out = r_locked_out;
  assign fail_count = r_fail;
  assign prog_done  = r_prog_done;

endmodule
